// File: rtl/muxcont_rr_pkg.sv
// rtl/muxcont_rr_pkg.sv - shared levels, state type and one-hot helper for the switch allocator
package muxcont_rr_pkg;

    localparam logic ENABLE_ = 1'b0;
    localparam logic ENABLE  = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Index of the set bit in a one-hot vector of up to 16 bits; 0 when empty.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/muxcont_rr_arb.sv
// rtl/muxcont_rr_arb.sv - combinational rotate-priority-rotate-back round-robin arbiter
module arb_rr #(
    parameter int NPORT = 5
) (
    input  logic [NPORT-1:0]         req,
    input  logic [$clog2(NPORT)-1:0] ptr,
    output logic [NPORT-1:0]         grt
);

    localparam int PW = $clog2(NPORT);

    logic [PW-1:0]      start;
    logic [2*NPORT-1:0] dbl_req;
    logic [NPORT-1:0]   rot;
    logic [NPORT-1:0]   pri;
    logic [2*NPORT-1:0] dbl_pri;

    // Rotate so the slot after ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        start   = (ptr == PW'(NPORT - 1)) ? '0 : ptr + PW'(1);
        dbl_req = {req, req} >> start;
        rot     = dbl_req[NPORT-1:0];
        pri     = rot & (~rot + NPORT'(1));
        dbl_pri = {pri, pri} << start;
        grt     = dbl_pri[2*NPORT-1:NPORT];
    end

endmodule

// File: rtl/muxcont_rr.sv
// rtl/muxcont_rr.sv - per-output-port switch allocator with packet lock and stall watchdog
module muxcont_rr
    import muxcont_rr_pkg::*;
#(
    parameter int NPORT    = 5,
    parameter int PORTW    = 3,
    parameter int PORTID   = 0,
    parameter int MAXSTALL = 16
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT*PORTW-1:0] dst,
    input  logic [NPORT-1:0]       req,
    input  logic [NPORT-1:0]       tail,
    input  logic                   ready,
    output logic [NPORT-1:0]       grt,
    output logic [NPORT-1:0]       sel,
    output logic                   busy,
    output logic                   stall_err
);

    localparam int PW = $clog2(NPORT);
    localparam int CW = (MAXSTALL > 1) ? $clog2(MAXSTALL + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXSTALL);

    state_t           state, state_nxt;
    logic [PW-1:0]    owner, ptr, win_idx;
    logic [NPORT-1:0] match, rr_grt;
    logic             hold, xfer, tail_xfer, new_lock;
    logic [CW-1:0]    stallcnt, stallcnt_nxt;

    // Inputs requesting this output port.
    always_comb begin
        match = '0;
        for (int i = 0; i < NPORT; i++) begin
            match[i] = req[i] && (dst[i*PORTW +: PORTW] == PORTW'(PORTID));
        end
    end

    arb_rr #(.NPORT(NPORT)) u_arb (
        .req (match),
        .ptr (ptr),
        .grt (rr_grt)
    );

    // Grant selection, transfer qualification, next state and watchdog count.
    always_comb begin
        hold      = (state == ST_LOCKED) && match[owner];
        grt       = hold ? (NPORT'(1) << owner) : rr_grt;
        win_idx   = PW'(onehot_to_idx(16'(grt)));
        xfer      = (|(grt & match)) && ready;
        tail_xfer = xfer && tail[win_idx];
        state_nxt = ST_IDLE;
        new_lock  = 1'b0;
        if ((|grt) && !tail_xfer) begin
            state_nxt = ST_LOCKED;
            new_lock  = !hold;
        end
        if ((state_nxt != ST_LOCKED) || xfer || new_lock) begin
            stallcnt_nxt = '0;
        end else if (stallcnt != CNT_MAX) begin
            stallcnt_nxt = stallcnt + CW'(1);
        end else begin
            stallcnt_nxt = stallcnt;
        end
    end

    // State, owner, pointer, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_ == ENABLE_) begin
            state     <= ST_IDLE;
            owner     <= '0;
            ptr       <= PW'(NPORT - 1);
            stallcnt  <= '0;
            sel       <= '0;
            busy      <= 1'b0;
            stall_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            stallcnt <= stallcnt_nxt;
            sel      <= grt;
            busy     <= (state_nxt == ST_LOCKED);
            if (state_nxt == ST_LOCKED) begin
                owner <= win_idx;
            end
            if (!hold && (|rr_grt)) begin
                ptr <= win_idx;
            end
            if ((MAXSTALL != 0) && (stallcnt_nxt == CNT_MAX)) begin
                stall_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_muxcont_rr.sv
// tb/tb_muxcont_rr.sv - directed self-checking bench for muxcont_rr
module tb_muxcont_rr;

    logic        clk;
    logic        rst_;
    logic [14:0] dst;
    logic [4:0]  req;
    logic [4:0]  tail;
    logic        ready;
    logic [4:0]  grt;
    logic [4:0]  sel;
    logic        busy;
    logic        stall_err;

    int n_cmp = 0;
    int n_bad = 0;

    muxcont_rr #(
        .NPORT(5), .PORTW(3), .PORTID(0), .MAXSTALL(16)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .dst       (dst),
        .req       (req),
        .tail      (tail),
        .ready     (ready),
        .grt       (grt),
        .sel       (sel),
        .busy      (busy),
        .stall_err (stall_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_ = 1'b0; req = '0; tail = '0; ready = 1'b0; dst = '0;
        step(); step();
        n_cmp++; if (sel !== 5'b00000) begin n_bad++; $display("FAIL reset_sel: got %b expected 00000", sel); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (stall_err !== 1'b0) begin n_bad++; $display("FAIL reset_stall_err: got %b expected 0", stall_err); end
        req = 5'b00110; #1;
        n_cmp++; if (grt !== 5'b00010) begin n_bad++; $display("FAIL reset_grt: got %b expected 00010", grt); end
        rst_ = 1'b1; req = '0;
        step();
    endtask

    task automatic test_rr_single_flit;
        logic [4:0] exp_g [4];
        exp_g = '{5'b00010, 5'b00100, 5'b10000, 5'b00010};
        dst = {3'd0, 3'd1, 3'd0, 3'd0, 3'd1};
        req = 5'b11111; tail = 5'b11111; ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (grt !== exp_g[i]) begin n_bad++; $display("FAIL rr_grt%0d: got %b expected %b", i, grt, exp_g[i]); end
            step();
            n_cmp++; if (sel !== exp_g[i]) begin n_bad++; $display("FAIL rr_sel%0d: got %b expected %b", i, sel, exp_g[i]); end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_busy%0d: got %b expected 0", i, busy); end
        end
        dst = '0; req = '0; tail = '0;
    endtask

    task automatic test_packet_lock;
        req = 5'b01001; ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            tail = (f == 3) ? 5'b01000 : 5'b00000;
            #1;
            n_cmp++; if (grt !== 5'b01000) begin n_bad++; $display("FAIL pkt_grt%0d: got %b expected 01000", f, grt); end
            step();
            n_cmp++; if (busy !== (f < 3)) begin n_bad++; $display("FAIL pkt_busy%0d: got %b expected %b", f, busy, (f < 3)); end
        end
        tail = 5'b00001; #1;
        n_cmp++; if (grt !== 5'b00001) begin n_bad++; $display("FAIL pkt_next_grt: got %b expected 00001", grt); end
        step();
        req = '0; tail = '0;
    endtask

    task automatic test_ready_stall;
        req = 5'b00100; tail = '0; ready = 1'b1; #1;
        n_cmp++; if (grt !== 5'b00100) begin n_bad++; $display("FAIL stall_grt_first: got %b expected 00100", grt); end
        step();
        for (int k = 0; k < 3; k++) begin
            ready = 1'b0; #1;
            n_cmp++; if (grt !== 5'b00100) begin n_bad++; $display("FAIL stall_grt%0d: got %b expected 00100", k, grt); end
            step();
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy%0d: got %b expected 1", k, busy); end
            n_cmp++; if (stall_err !== 1'b0) begin n_bad++; $display("FAIL stall_err%0d: got %b expected 0", k, stall_err); end
        end
        ready = 1'b1; tail = 5'b00100; #1;
        n_cmp++; if (grt !== 5'b00100) begin n_bad++; $display("FAIL stall_grt_tail: got %b expected 00100", grt); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_busy_release: got %b expected 0", busy); end
        req = '0; tail = '0;
    endtask

    task automatic test_watchdog;
        req = 5'b01000; tail = '0; ready = 1'b1; #1;
        n_cmp++; if (grt !== 5'b01000) begin n_bad++; $display("FAIL wd_grt: got %b expected 01000", grt); end
        step();
        ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 15) begin
                n_cmp++; if (stall_err !== 1'b0) begin n_bad++; $display("FAIL wd_early: got %b expected 0", stall_err); end
            end
            if (i == 16) begin
                n_cmp++; if (stall_err !== 1'b1) begin n_bad++; $display("FAIL wd_rise: got %b expected 1", stall_err); end
                n_cmp++; if (grt !== 5'b01000) begin n_bad++; $display("FAIL wd_lock_kept: got %b expected 01000", grt); end
            end
        end
        ready = 1'b1;
        step();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wd_busy: got %b expected 1", busy); end
        tail = 5'b01000;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wd_release: got %b expected 0", busy); end
        n_cmp++; if (stall_err !== 1'b1) begin n_bad++; $display("FAIL wd_sticky: got %b expected 1", stall_err); end
        req = '0; tail = '0;
    endtask

    task automatic test_owner_drop;
        req = 5'b00100; tail = '0; ready = 1'b1; #1;
        n_cmp++; if (grt !== 5'b00100) begin n_bad++; $display("FAIL drop_first: got %b expected 00100", grt); end
        step();
        req = 5'b10100; #1;
        n_cmp++; if (grt !== 5'b00100) begin n_bad++; $display("FAIL drop_hold: got %b expected 00100", grt); end
        step();
        req = 5'b10000; #1;
        n_cmp++; if (grt !== 5'b10000) begin n_bad++; $display("FAIL drop_switch: got %b expected 10000", grt); end
        step();
        n_cmp++; if (sel !== 5'b10000) begin n_bad++; $display("FAIL drop_sel: got %b expected 10000", sel); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL drop_busy: got %b expected 1", busy); end
        tail = 5'b10000;
        step();
        req = '0; tail = '0;
    endtask

    task automatic test_reset_lock;
        req = 5'b01000; tail = '0; ready = 1'b1; #1;
        n_cmp++; if (grt !== 5'b01000) begin n_bad++; $display("FAIL rl_grt: got %b expected 01000", grt); end
        step();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rl_busy_locked: got %b expected 1", busy); end
        rst_ = 1'b0; req = 5'b01001;
        step();
        rst_ = 1'b1; #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rl_busy: got %b expected 0", busy); end
        n_cmp++; if (sel !== 5'b00000) begin n_bad++; $display("FAIL rl_sel: got %b expected 00000", sel); end
        n_cmp++; if (stall_err !== 1'b0) begin n_bad++; $display("FAIL rl_stall_err: got %b expected 0", stall_err); end
        n_cmp++; if (grt !== 5'b00001) begin n_bad++; $display("FAIL rl_grt_after: got %b expected 00001", grt); end
        step();
        n_cmp++; if (sel !== 5'b00001) begin n_bad++; $display("FAIL rl_sel_after: got %b expected 00001", sel); end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_rr_single_flit();
        test_packet_lock();
        test_ready_stall();
        test_watchdog();
        test_owner_drop();
        test_reset_lock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
